// File: rtl/lbc_pkg.sv
// ---------------------------------------------------------------------------
// lbc_pkg
//   Shared constants and types for the linear-block-code datapath.
//   Codeword = 32 data bits + 6 parity bits.  The serializer FSM state type
//   lives here so anything observing the serializer can name its states.
// ---------------------------------------------------------------------------
package lbc_pkg;

   localparam int DATA_WIDTH   = 32;
   localparam int PARITY_WIDTH = 6;
   localparam int CW_WIDTH     = DATA_WIDTH + PARITY_WIDTH;

   typedef logic [CW_WIDTH-1:0] lbc_cw_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } ser_state_e;

endpackage : lbc_pkg

// File: rtl/lbc_cw_hold.sv
// ---------------------------------------------------------------------------
// lbc_cw_hold
//   One-entry holding register in front of the serializer shift register.
//   Ports:
//     clk, rst_n        clock, async active-low reset
//     in_valid/in_ready upstream handshake; in_ready is the inverse of the
//                       full flop, so it never depends on pop
//     in_data           word captured on an accepting edge
//     out_data          held word
//     out_full          entry occupied
//     pop               consumer takes the entry this edge (only while full)
//
//   Handshake: a word transfers on a rising edge where in_valid && in_ready.
//   in_valid may rise at any time; in_data must be stable while in_valid is
//   high and not yet accepted.  Because in_ready is low whenever the entry is
//   full, an accept and a pop can never happen on the same edge.
// ---------------------------------------------------------------------------
module lbc_cw_hold #(
   parameter int W = 38
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic [W-1:0] out_data,
   output logic         out_full,
   input  logic         pop
);

   logic         full_q;
   logic [W-1:0] data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else if (in_valid && in_ready) begin
         full_q <= 1'b1;
         data_q <= in_data;
      end else if (pop) begin
         full_q <= 1'b0;
      end
   end

   assign in_ready = ~full_q;
   assign out_full = full_q;
   assign out_data = data_q;

endmodule : lbc_cw_hold

// File: rtl/lbc_codeword_serializer.sv
// ---------------------------------------------------------------------------
// lbc_codeword_serializer
//   Double-buffers encoder codewords (hold register + shift register) and
//   sends them one bit per tx_en strobe, flagging first/last bit of each
//   frame.  Optional idle strobes separate frames.
//   Ports:
//     clk, rst_n          clock, async active-low reset
//     cw_in/cw_valid/cw_ready  codeword input handshake (see lbc_cw_hold)
//     tx_en               line-rate strobe; nothing advances while low
//                         (except the IDLE load, which ignores it)
//     tx_bit/tx_valid     serial data, 0 whenever tx_valid=0
//     tx_sof/tx_eof       first / last bit of the current frame
//     busy                frame in progress, in gap, or word held
//     frames_sent         wrapping count of completed frames
// ---------------------------------------------------------------------------
module lbc_codeword_serializer #(
   parameter int CW_WIDTH   = lbc_pkg::CW_WIDTH,
   parameter bit MSB_FIRST  = 1'b1,
   parameter int GAP_CYCLES = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CW_WIDTH-1:0] cw_in,
   input  logic                cw_valid,
   output logic                cw_ready,
   input  logic                tx_en,
   output logic                tx_bit,
   output logic                tx_valid,
   output logic                tx_sof,
   output logic                tx_eof,
   output logic                busy,
   output logic [15:0]         frames_sent
);

   import lbc_pkg::*;

   localparam int                CNT_W    = $clog2(CW_WIDTH);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CW_WIDTH - 1);
   // Only meaningful when GAP_CYCLES > 0; the GAP state is unreachable otherwise.
   localparam logic [7:0]        GAP_LAST = 8'(GAP_CYCLES - 1);

   ser_state_e          state;
   logic [CW_WIDTH-1:0] sreg;
   logic [CNT_W-1:0]    cnt;
   logic [7:0]          gap_cnt;

   logic [CW_WIDTH-1:0] hold_data;
   logic                hold_full;
   logic                hold_pop;

   lbc_cw_hold #(.W(CW_WIDTH)) u_hold (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (cw_valid),
      .in_ready (cw_ready),
      .in_data  (cw_in),
      .out_data (hold_data),
      .out_full (hold_full),
      .pop      (hold_pop)
   );

   logic last_strobe;
   logic gap_done;

   assign last_strobe = (state == SHIFT) && tx_en && (cnt == CNT_LAST);
   assign gap_done    = (state == GAP) && tx_en && (gap_cnt == GAP_LAST);

   // Edges on which the shift register takes the held word.
   always_comb begin
      hold_pop = 1'b0;
      case (state)
         IDLE:    hold_pop = hold_full;
         SHIFT:   hold_pop = last_strobe && (GAP_CYCLES == 0) && hold_full;
         GAP:     hold_pop = gap_done && hold_full;
         default: hold_pop = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         sreg        <= '0;
         cnt         <= '0;
         gap_cnt     <= '0;
         frames_sent <= '0;
      end else begin
         if (last_strobe) begin
            frames_sent <= frames_sent + 16'd1;
         end
         case (state)
            IDLE: begin
               if (hold_pop) begin
                  sreg  <= hold_data;
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (tx_en) begin
                  if (cnt != CNT_LAST) begin
                     // Move the next bit toward whichever end drives tx_bit.
                     if (MSB_FIRST) sreg <= {sreg[CW_WIDTH-2:0], 1'b0};
                     else           sreg <= {1'b0, sreg[CW_WIDTH-1:1]};
                     cnt <= cnt + 1'b1;
                  end else if (GAP_CYCLES > 0) begin
                     gap_cnt <= '0;
                     state   <= GAP;
                  end else if (hold_pop) begin
                     sreg <= hold_data;
                     cnt  <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            GAP: begin
               if (tx_en) begin
                  if (gap_done) begin
                     if (hold_pop) begin
                        sreg  <= hold_data;
                        cnt   <= '0;
                        state <= SHIFT;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     gap_cnt <= gap_cnt + 8'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Serial outputs decode straight from state/cnt/sreg flops.
   assign tx_valid = (state == SHIFT);
   assign tx_bit   = tx_valid & (MSB_FIRST ? sreg[CW_WIDTH-1] : sreg[0]);
   assign tx_sof   = tx_valid && (cnt == '0);
   assign tx_eof   = tx_valid && (cnt == CNT_LAST);
   assign busy     = (state != IDLE) || hold_full;

endmodule : lbc_codeword_serializer

// File: tb/tb_lbc_codeword_serializer.sv
// ---------------------------------------------------------------------------
// tb_lbc_codeword_serializer
//   Two serializers side by side: d0 = MSB first, no gap; d1 = LSB first,
//   3 idle strobes between frames.  Each is compared every cycle against a
//   frame-level reference model (current frame + bit position, pending word,
//   remaining gap strobes).
// ---------------------------------------------------------------------------
module tb_lbc_codeword_serializer;

   localparam int W = 38;

   logic clk;
   logic rst_n;

   logic [W-1:0] cw_in_a    [2];
   logic         cw_valid_a [2];
   logic         tx_en_a    [2];

   logic        cw_ready0, tx_bit0, tx_valid0, tx_sof0, tx_eof0, busy0;
   logic [15:0] frames0;
   logic        cw_ready1, tx_bit1, tx_valid1, tx_sof1, tx_eof1, busy1;
   logic [15:0] frames1;

   lbc_codeword_serializer #(.CW_WIDTH(W), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .cw_in(cw_in_a[0]), .cw_valid(cw_valid_a[0]), .cw_ready(cw_ready0),
      .tx_en(tx_en_a[0]), .tx_bit(tx_bit0), .tx_valid(tx_valid0),
      .tx_sof(tx_sof0), .tx_eof(tx_eof0), .busy(busy0), .frames_sent(frames0)
   );

   lbc_codeword_serializer #(.CW_WIDTH(W), .MSB_FIRST(1'b0), .GAP_CYCLES(3)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .cw_in(cw_in_a[1]), .cw_valid(cw_valid_a[1]), .cw_ready(cw_ready1),
      .tx_en(tx_en_a[1]), .tx_bit(tx_bit1), .tx_valid(tx_valid1),
      .tx_sof(tx_sof1), .tx_eof(tx_eof1), .busy(busy1), .frames_sent(frames1)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [W-1:0] exp_q0[$];   // words still to be offered to d0
   logic [W-1:0] exp_q1[$];   // words still to be offered to d1

   // Reference model, one set per DUT.
   bit           m_hf    [2];
   logic [W-1:0] m_hold  [2];
   bit           m_shift [2];
   logic [W-1:0] m_cur   [2];
   int           m_pos   [2];
   int           m_gapl  [2];
   int unsigned  m_frames[2];

   int run_len, max_run;

   function automatic int gap_of(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   function automatic bit msb_of(input int d);
      return (d == 0);
   endfunction

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_hf[d]     = 0;
         m_hold[d]   = '0;
         m_shift[d]  = 0;
         m_cur[d]    = '0;
         m_pos[d]    = 0;
         m_gapl[d]   = 0;
         m_frames[d] = 0;
      end
   endtask

   // Advance model d across one rising edge; returns 1 when the offered
   // word was taken.
   function automatic bit model_edge(input int d);
      bit hf  = m_hf[d];
      bit acc = cw_valid_a[d] && !hf;
      bit ld  = 0;
      if (m_shift[d]) begin
         if (tx_en_a[d]) begin
            if (m_pos[d] == W - 1) begin
               m_frames[d] = (m_frames[d] + 1) & 32'hFFFF;
               m_shift[d]  = 0;
               if (gap_of(d) > 0) m_gapl[d] = gap_of(d);
               else if (hf)       ld = 1;
            end else begin
               m_pos[d]++;
            end
         end
      end else if (m_gapl[d] > 0) begin
         if (tx_en_a[d]) begin
            m_gapl[d]--;
            if (m_gapl[d] == 0 && hf) ld = 1;
         end
      end else if (hf) begin
         ld = 1;
      end
      if (ld) begin
         m_cur[d]   = m_hold[d];
         m_pos[d]   = 0;
         m_shift[d] = 1;
         m_hf[d]    = 0;
      end
      if (acc) begin
         m_hold[d] = cw_in_a[d];
         m_hf[d]   = 1;
      end
      return acc;
   endfunction

   task automatic compare_dut(input int d, input logic bit_a, input logic valid_a,
                              input logic sof_a, input logic eof_a, input logic ready_a,
                              input logic busy_a, input logic [15:0] fs_a);
      logic e_bit;
      e_bit = 1'b0;
      if (m_shift[d]) e_bit = msb_of(d) ? m_cur[d][W-1-m_pos[d]] : m_cur[d][m_pos[d]];
      check($sformatf("d%0d_tx_bit", d),   64'(bit_a),   64'(e_bit));
      check($sformatf("d%0d_tx_valid", d), 64'(valid_a), 64'(m_shift[d]));
      check($sformatf("d%0d_tx_sof", d),   64'(sof_a),   64'(m_shift[d] && m_pos[d] == 0));
      check($sformatf("d%0d_tx_eof", d),   64'(eof_a),   64'(m_shift[d] && m_pos[d] == W - 1));
      check($sformatf("d%0d_cw_ready", d), 64'(ready_a), 64'(!m_hf[d]));
      check($sformatf("d%0d_busy", d),     64'(busy_a),  64'(m_shift[d] || m_gapl[d] > 0 || m_hf[d]));
      check($sformatf("d%0d_frames", d),   64'(fs_a),    64'(m_frames[d]));
   endtask

   task automatic compare_all();
      compare_dut(0, tx_bit0, tx_valid0, tx_sof0, tx_eof0, cw_ready0, busy0, frames0);
      compare_dut(1, tx_bit1, tx_valid1, tx_sof1, tx_eof1, cw_ready1, busy1, frames1);
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_inputs();
      logic [63:0] r;
      for (int d = 0; d < 2; d++) begin
         r = {$urandom, $urandom};
         if (d == 0 && exp_q0.size() > 0) begin
            cw_valid_a[0] = 1'b1;
            cw_in_a[0]    = exp_q0[0];
         end else if (d == 1 && exp_q1.size() > 0) begin
            cw_valid_a[1] = 1'b1;
            cw_in_a[1]    = exp_q1[0];
         end else begin
            cw_valid_a[d] = 1'b0;
            cw_in_a[d]    = r[W-1:0];   // must be ignored
         end
      end
   endtask

   task automatic push_both(input logic [W-1:0] w);
      exp_q0.push_back(w);
      exp_q1.push_back(w);
      drive_inputs();
   endtask

   task automatic set_tx_en(input logic e0, input logic e1);
      tx_en_a[0] = e0;
      tx_en_a[1] = e1;
   endtask

   // One clock: update the model across the edge, then compare 1 time unit later.
   task automatic step();
      bit acc;
      @(posedge clk);
      cyc++;
      if (rst_n) begin
         for (int d = 0; d < 2; d++) begin
            acc = model_edge(d);
            if (acc && d == 0) void'(exp_q0.pop_front());
            if (acc && d == 1) void'(exp_q1.pop_front());
         end
      end
      #1;
      compare_all();
      if (tx_valid0) run_len++;
      else           run_len = 0;
      if (run_len > max_run) max_run = run_len;
      drive_inputs();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit reached;
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         cw_in_a[d]    = '0;
         cw_valid_a[d] = 1'b0;
         tx_en_a[d]    = 1'b0;
      end
      model_reset();
      run_len = 0;
      max_run = 0;

      // Reset / idle
      #12;
      compare_all();
      @(posedge clk);
      #1 rst_n = 1'b1;
      run(4);

      // Single frame, continuous strobe
      set_tx_en(1'b1, 1'b1);
      push_both(38'h20_0000_0001);
      run(60);
      check("single_frames_d0", 64'(frames0), 64'd1);

      // Back-to-back plus backpressure: three words queued at once
      max_run = 0;
      push_both(38'h3F_FFFF_FFFF);
      push_both(38'h00_0000_0000);
      push_both(38'h15_A5A5_C33C);
      run(140);
      check("b2b_contiguous_valid_d0", 64'(max_run), 64'(3 * W));

      // Stall/gap: strobe every 3rd cycle
      push_both(38'h2A_5555_AAAA);
      push_both(38'h01_F0F0_0F0F);
      for (int i = 0; i < 320; i++) begin
         set_tx_en(i % 3 == 0, i % 3 == 0);
         step();
      end

      // Random strobes and random arrivals
      for (int i = 0; i < 1500; i++) begin
         logic [63:0] r;
         set_tx_en($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
         if (exp_q0.size() < 3 && $urandom_range(0, 9) == 0) begin
            r = {$urandom, $urandom};
            push_both(r[W-1:0]);
         end
         step();
      end
      set_tx_en(1'b1, 1'b1);
      run(200);

      // Reset in the middle of a frame (d0 at bit 20)
      push_both(38'h3F_0000_FFFF);
      push_both(38'h12_3456_789A);
      reached = 0;
      for (int i = 0; i < 200 && !reached; i++) begin
         step();
         if (m_shift[0] && m_pos[0] == 20) reached = 1;
      end
      check("reset_point_reached", 64'(reached), 64'd1);
      #3 rst_n = 1'b0;
      #1;
      check("rst_tx_valid_d0", 64'(tx_valid0), 64'd0);
      check("rst_tx_valid_d1", 64'(tx_valid1), 64'd0);
      check("rst_frames_d0",   64'(frames0),   64'd0);
      check("rst_cw_ready_d0", 64'(cw_ready0), 64'd1);
      model_reset();
      exp_q0.delete();
      exp_q1.delete();
      drive_inputs();
      run(3);
      #2 rst_n = 1'b1;
      push_both(38'h2B_CAFE_BEEF);
      run(60);
      check("post_reset_frames_d0", 64'(frames0), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_lbc_codeword_serializer
